data_write_buffer: RTL and testbench

Store queue between the data cache/LSU and the cache-AXI interface's single-word data write channel. It accepts full-word stores at one per cycle into an in-order FIFO and drains them one at a time through the interface's `data_wen`/`data_bvalid` handshake. The CPU therefore does not stall for AXI write latency. It also checks pending entries against the current load address, so loads never read stale memory.

---
 rtl/data_write_buffer_pkg.sv | 14 +
 rtl/data_write_buffer_match.sv | 42 ++++
 rtl/data_write_buffer.sv | 164 ++++++++++++++++
 tb/tb_data_write_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_write_buffer_pkg.sv
// Shared definitions for the data write buffer: drain FSM encoding and sizing constants.
package data_write_buffer_pkg;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } wb_state_e;

  localparam int WB_DEFAULT_DEPTH = 8;

  // Lowest address bit that takes part in word addressing.
  localparam int WB_WORD_LSB = 2;

endpackage

// File: rtl/data_write_buffer_match.sv
// wb_match_unit: parallel word-address comparators over all live entries and a
// youngest-first priority select of the matching entry's data.
module wb_match_unit #(
  parameter int DEPTH  = 8,
  parameter int WA_W   = 30,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WA_W-1:0]   entry_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic [DEPTH-1:0]             valid,
  input  logic [PTR_W-1:0]             tail,
  input  logic [WA_W-1:0]              lookup_addr,
  output logic [DEPTH-1:0]             match,
  output logic [DATA_W-1:0]            hit_data,
  output logic                         any_match
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (entry_addr[i] == lookup_addr);
    end
  end

  assign any_match = |match;

  // Walk from the oldest slot toward tail-1 so the youngest match is written last and wins.
  always_comb begin
    hit_data = '0;
    idx      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PTR_W'(k + 1);
      if (match[idx]) begin
        hit_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/data_write_buffer.sv
// data_write_buffer: in-order store queue draining one word at a time to the cache-AXI write channel.
// Build macro WB_FORWARD_EN forwards the youngest matching store to loads instead of stalling them.
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEFAULT_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_wen_i,
  input  logic [ADDR_W-1:0]        wb_waddr_i,
  input  logic [DATA_W-1:0]        wb_wdata_i,
  output logic                     wb_full_o,
  output logic                     wb_empty_o,
  input  logic                     rd_req_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic                     rd_hit_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_stall_o,
  output logic                     data_wen_o,
  output logic [ADDR_W-1:0]        data_awaddr_o,
  output logic [DATA_W-1:0]        data_wdata_o,
  input  logic                     data_bvalid_i,
  output wb_state_e                dbg_state_o,
  output logic [$clog2(DEPTH):0]   dbg_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - WB_WORD_LSB;

  // Handshakes: a store transfers on a rising edge with wb_wen_i=1 and wb_full_o=0.
  // data_wen_o stays high with a stable head entry until the edge that samples data_bvalid_i=1.

  logic [DEPTH-1:0][WA_W-1:0]   addr_mem;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;
  wb_state_e                    state;
  logic                         wen_q;

  logic                         push;
  logic                         pop;
  logic [WA_W-1:0]              rd_word;
  logic [WA_W-1:0]              wr_word;
  logic                         conflict;
  logic [DEPTH-1:0]             valid;
  logic [PTR_W-1:0]             off;
  logic [DEPTH-1:0]             match_vec;
  logic [DATA_W-1:0]            hit_data;
  logic                         any_match;
  logic                         unused_bits;

  assign wb_full_o  = (count == CNT_W'(DEPTH));
  assign wb_empty_o = (count == '0) && (state == WB_IDLE);

  assign push    = wb_wen_i && !wb_full_o;
  assign pop     = (state == WB_DRAIN) && data_bvalid_i;
  assign wr_word = wb_waddr_i[ADDR_W-1:WB_WORD_LSB];
  assign rd_word = rd_addr_i[ADDR_W-1:WB_WORD_LSB];

  // Storage is cleared on reset so the head-entry outputs read zero until the first store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_mem <= '0;
      data_mem <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        addr_mem[tail] <= wr_word;
        data_mem[tail] <= wb_wdata_i;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WB_IDLE;
      wen_q <= 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (count != '0) begin
            state <= WB_DRAIN;
            wen_q <= 1'b1;
          end
        end
        WB_DRAIN: begin
          if (data_bvalid_i) begin
            state <= WB_IDLE;
            wen_q <= 1'b0;
          end
        end
        default: begin
          state <= WB_IDLE;
          wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_wen_o    = wen_q;
  assign data_awaddr_o = {addr_mem[head], {WB_WORD_LSB{1'b0}}};
  assign data_wdata_o  = data_mem[head];
  assign dbg_state_o   = state;
  assign dbg_count_o   = count;

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head;
      valid[i] = ({1'b0, off} < count);
    end
  end

  wb_match_unit #(
    .DEPTH  (DEPTH),
    .WA_W   (WA_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .entry_addr  (addr_mem),
    .entry_data  (data_mem),
    .valid       (valid),
    .tail        (tail),
    .lookup_addr (rd_word),
    .match       (match_vec),
    .hit_data    (hit_data),
    .any_match   (any_match)
  );

  assign conflict = rd_req_i && push && (wr_word == rd_word);

`ifdef WB_FORWARD_EN
  // An older match must not be forwarded while a newer store to the same word is landing.
  assign rd_hit_o   = rd_req_i && any_match && !conflict;
  assign rd_data_o  = rd_hit_o ? hit_data : '0;
  assign rd_stall_o = conflict;
`else
  assign rd_hit_o   = 1'b0;
  assign rd_data_o  = '0;
  assign rd_stall_o = rd_req_i && (any_match || conflict);
`endif

  assign unused_bits = ^{wb_waddr_i[WB_WORD_LSB-1:0], rd_addr_i[WB_WORD_LSB-1:0],
                         match_vec, hit_data};

endmodule

// File: tb/tb_data_write_buffer.sv
// Bench for data_write_buffer: directed vector table, queue-based reference model with
// random stimulus, and hand sequences for fill, push/pop overlap and reset mid-drain.
module tb_data_write_buffer;
  import data_write_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WA_W  = AW - 2;
  localparam int ENT_W = WA_W + DW;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            full;
  logic            empty;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_hit;
  logic [DW-1:0]   rd_data;
  logic            rd_stall;
  logic            data_wen;
  logic [AW-1:0]   awaddr;
  logic [DW-1:0]   wdata_out;
  logic            bvalid;
  wb_state_e       dbg_state;
  logic [3:0]      dbg_count;

  data_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_wen_i      (wen),
    .wb_waddr_i    (waddr),
    .wb_wdata_i    (wdata),
    .wb_full_o     (full),
    .wb_empty_o    (empty),
    .rd_req_i      (rd_req),
    .rd_addr_i     (rd_addr),
    .rd_hit_o      (rd_hit),
    .rd_data_o     (rd_data),
    .rd_stall_o    (rd_stall),
    .data_wen_o    (data_wen),
    .data_awaddr_o (awaddr),
    .data_wdata_o  (wdata_out),
    .data_bvalid_i (bvalid),
    .dbg_state_o   (dbg_state),
    .dbg_count_o   (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks;
  int n_fail;
  logic [ENT_W-1:0] exp_q[$];
  bit m_drain;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_model();
    int n;
    bit push_ok, conflict, match, e_hit, e_stall;
    logic [WA_W-1:0] rw;
    logic [DW-1:0] ydata, e_data;
    n = exp_q.size();
    push_ok = wen && (n < DEPTH);
    rw = rd_addr[AW-1:2];
    conflict = rd_req && push_ok && (waddr[AW-1:2] == rw);
    match = 1'b0;
    ydata = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i][ENT_W-1:DW] == rw) begin
        match = 1'b1;
        ydata = exp_q[i][DW-1:0];
      end
    end
    match = match && rd_req;
    if (FWD) begin
      e_hit = match && !conflict;
      e_data = e_hit ? ydata : '0;
      e_stall = conflict;
    end else begin
      e_hit = 1'b0;
      e_data = '0;
      e_stall = match || conflict;
    end
    chk("full", full, n == DEPTH);
    chk("empty", empty, (n == 0) && !m_drain);
    chk("data_wen", data_wen, m_drain);
    chk("count", dbg_count, n);
    chk("state", dbg_state, m_drain ? WB_DRAIN : WB_IDLE);
    chk("rd_hit", rd_hit, e_hit);
    chk("rd_data", rd_data, e_data);
    chk("rd_stall", rd_stall, e_stall);
    if (n > 0) begin
      chk("head_awaddr", awaddr, {exp_q[0][ENT_W-1:DW], 2'b00});
      chk("head_wdata", wdata_out, exp_q[0][DW-1:0]);
    end
    if (m_drain && bvalid && n > 0) begin
      chk("write_commit", {awaddr[AW-1:2], wdata_out}, exp_q[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wen = 1'b0; waddr = '0; wdata = '0;
    rd_req = 1'b0; rd_addr = '0; bvalid = 1'b0;
  endtask

  task automatic settle_check();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    bit push_ok, pop, was_nonempty;
    logic [ENT_W-1:0] ent;
    push_ok = wen && (exp_q.size() < DEPTH);
    pop = m_drain && bvalid;
    was_nonempty = exp_q.size() != 0;
    ent = {waddr[AW-1:2], wdata};
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      m_drain = 1'b0;
    end else begin
      if (m_drain) m_drain = !bvalid;
      else m_drain = was_nonempty;
      if (pop) void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(ent);
    end
    #1;
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  task automatic drain_all();
    int guard;
    guard = 0;
    drive_idle();
    while ((exp_q.size() != 0 || m_drain) && guard < 200) begin
      bvalid = m_drain;
      cycle();
      guard++;
    end
    bvalid = 1'b0;
    if (guard >= 200) chk("drain_timeout", 1, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          bvalid;
    logic          e_wen, e_empty, e_full, e_stall, e_hit;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] e_awaddr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                              input logic rq, input logic [31:0] ra, input logic bv,
                              input logic ew, input logic ee, input logic ef, input logic es,
                              input logic eh, input logic [31:0] erd, input logic [31:0] eaa,
                              input logic [31:0] ewd);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd; v.rd_req = rq; v.rd_addr = ra; v.bvalid = bv;
    v.e_wen = ew; v.e_empty = ee; v.e_full = ef; v.e_stall = es; v.e_hit = eh;
    v.e_rdata = erd; v.e_awaddr = eaa; v.e_wdata = ewd;
    return v;
  endfunction

  initial begin
    logic [31:0] beef, a0, f2;
    int guard;
    n_checks = 0;
    n_fail = 0;
    m_drain = 1'b0;
    rst = 1'b0;
    drive_idle();

    beef = 32'hDEAD_BEEF;
    a0 = 32'h8000_0104;
    f2 = FWD ? 32'd2 : 32'd0;
    //            wen waddr  wdata rq rd_addr       bv | wen emp full stall    hit  rdata               awaddr     wdata
    tbl[0]  = mk(0, 0,      0,    0, 0,            0,   0,  1,  0,   0,       0,   0,                  0,         0);
    tbl[1]  = mk(1, a0,     beef, 1, a0,           0,   0,  1,  0,   1,       0,   0,                  0,         0);
    tbl[2]  = mk(0, 0,      0,    1, 32'h8000_0106, 0,  0,  0,  0,   !FWD,    FWD, FWD ? beef : 32'd0, a0,        beef);
    tbl[3]  = mk(0, 0,      0,    0, 0,            0,   1,  0,  0,   0,       0,   0,                  a0,        beef);
    tbl[4]  = mk(0, 0,      0,    1, 32'h100,      0,   1,  0,  0,   0,       0,   0,                  a0,        beef);
    tbl[5]  = mk(0, 0,      0,    0, 0,            0,   1,  0,  0,   0,       0,   0,                  a0,        beef);
    tbl[6]  = mk(0, 0,      0,    0, 0,            1,   1,  0,  0,   0,       0,   0,                  a0,        beef);
    tbl[7]  = mk(0, 0,      0,    0, 0,            0,   0,  1,  0,   0,       0,   0,                  0,         0);
    tbl[8]  = mk(1, 32'h100, 1,   0, 0,            0,   0,  1,  0,   0,       0,   0,                  0,         0);
    tbl[9]  = mk(1, 32'h100, 2,   0, 0,            0,   0,  0,  0,   0,       0,   0,                  32'h100,   1);
    tbl[10] = mk(0, 0,      0,    1, 32'h102,      0,   1,  0,  0,   !FWD,    FWD, f2,                 32'h100,   1);
    tbl[11] = mk(0, 0,      0,    1, 32'h102,      1,   1,  0,  0,   !FWD,    FWD, f2,                 32'h100,   1);
    tbl[12] = mk(0, 0,      0,    1, 32'h102,      0,   0,  0,  0,   !FWD,    FWD, f2,                 32'h100,   2);
    tbl[13] = mk(0, 0,      0,    1, 32'h102,      1,   1,  0,  0,   !FWD,    FWD, f2,                 32'h100,   2);
    tbl[14] = mk(0, 0,      0,    1, 32'h102,      0,   0,  1,  0,   0,       0,   0,                  0,         0);

    // Reset state, before any clock edge.
    #2;
    chk("rst_wen", data_wen, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata_out, 0);
    chk("rst_count", dbg_count, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      rd_req = tbl[i].rd_req; rd_addr = tbl[i].rd_addr; bvalid = tbl[i].bvalid;
      settle_check();
      chk($sformatf("tbl%0d_wen", i), data_wen, tbl[i].e_wen);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("tbl%0d_stall", i), rd_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_hit", i), rd_hit, tbl[i].e_hit);
      chk($sformatf("tbl%0d_rdata", i), rd_data, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_awaddr", i), awaddr, tbl[i].e_awaddr);
      chk($sformatf("tbl%0d_wdata", i), wdata_out, tbl[i].e_wdata);
      tick();
    end

    // Random traffic against the queue model; small address pool forces matches.
    for (int i = 0; i < 400; i++) begin
      wen = ($urandom_range(0, 2) != 0);
      waddr = 32'h1000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
      wdata = $urandom;
      rd_req = $urandom_range(0, 1);
      rd_addr = 32'h1000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
      bvalid = ($urandom_range(0, 2) == 0);
      cycle();
    end
    drain_all();

    // Fill: nine back-to-back stores, response withheld; the ninth is refused.
    for (int i = 0; i < 9; i++) begin
      wen = 1'b1; waddr = 32'h3000 + i * 4; wdata = 32'hA0 + i; bvalid = 1'b0;
      settle_check();
      if (i == 8) begin
        chk("fill_full", full, 1);
        chk("fill_count8", dbg_count, 8);
      end
      tick();
    end
    drive_idle();
    settle_check();
    chk("fill_refused", dbg_count, 8);
    chk("fill_first_head", awaddr, 32'h3000);
    tick();

    // Drain down to three entries, then overlap a push with the response.
    guard = 0;
    while (exp_q.size() > 3 && guard < 100) begin
      bvalid = m_drain;
      cycle();
      guard++;
    end
    bvalid = 1'b0;
    while (!m_drain && guard < 100) begin
      cycle();
      guard++;
    end
    if (guard >= 100) chk("pushpop_timeout", 1, 0);
    settle_check();
    chk("pushpop_head", awaddr, 32'h3014);
    tick();
    wen = 1'b1; waddr = 32'h4000; wdata = 32'h55; bvalid = 1'b1;
    cycle();
    drive_idle();
    settle_check();
    chk("pushpop_count", dbg_count, 3);
    chk("pushpop_next_head", awaddr, 32'h3018);
    tick();
    drain_all();

    // Reset while draining four entries.
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; waddr = 32'h5000 + i * 4; wdata = 32'hC0 + i;
      cycle();
    end
    drive_idle();
    settle_check();
    chk("pre_reset_wen", data_wen, 1);
    chk("pre_reset_count", dbg_count, 4);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_drain = 1'b0;
    #1;
    chk("async_rst_wen", data_wen, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_full", full, 0);
    chk("async_rst_awaddr", awaddr, 0);
    chk("async_rst_wdata", wdata_out, 0);
    chk("async_rst_count", dbg_count, 0);
    cycle();
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bvalid = (i == 2);
      cycle();
    end
    drive_idle();
    settle_check();
    chk("post_rst_empty", empty, 1);
    chk("post_rst_wen", data_wen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
